// File: rtl/ysyx_22050078_wb_unit_if.sv
// Writeback-stage bundle: ALU results, handshaked load results, decode hazard
// queries and the register-file write port.
interface ysyx_22050078_wb_unit_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
);
    logic                    alu_valid;
    logic [ADDR_WIDTH-1:0]   alu_rd;
    logic [DATA_WIDTH-1:0]   alu_data;
    logic                    lsu_valid;
    logic                    lsu_ready;
    logic [ADDR_WIDTH-1:0]   lsu_rd;
    logic [DATA_WIDTH-1:0]   lsu_data;
    logic                    iss_valid;
    logic                    iss_is_load;
    logic [ADDR_WIDTH-1:0]   iss_rd;
    logic [ADDR_WIDTH-1:0]   rs1_addr;
    logic [ADDR_WIDTH-1:0]   rs2_addr;
    logic                    rs1_busy;
    logic                    rs2_busy;
    logic                    alu_stall;
    logic                    w_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [$clog2(DEPTH):0]  buf_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_is_load, iss_rd, rs1_addr, rs2_addr,
        input  lsu_ready, rs1_busy, rs2_busy, alu_stall,
        input  w_en, wr_addr, wr_data, buf_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_is_load, iss_rd, rs1_addr, rs2_addr,
        output lsu_ready, rs1_busy, rs2_busy, alu_stall,
        output w_en, wr_addr, wr_data, buf_count
    );
endinterface

// File: rtl/ysyx_22050078_wb_unit.sv
// Writeback stage: merges ALU results with FIFO-buffered load results onto the
// single regfile write port and tracks in-flight loads in a busy scoreboard.
module ysyx_22050078_wb_unit #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ysyx_22050078_wb_unit_if.slave wb
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int SW   = $clog2(STARVE_LIMIT) + 1;

    logic [ADDR_WIDTH-1:0] fifo_rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  stall_q, stall_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  fifo_empty, fifo_full, lsu_ready, push, pop, take_alu;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign lsu_ready  = rst_n && !fifo_full;
    assign push       = wb.lsu_valid && lsu_ready;
    // A forced drain outranks the ALU; otherwise loads only fill ALU bubbles.
    assign pop        = !fifo_empty && (stall_q || !wb.alu_valid);
    assign take_alu   = !stall_q && wb.alu_valid;
    assign head_rd    = fifo_rd_q[rptr_q];
    assign head_data  = fifo_data_q[rptr_q];

    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pop) begin
            wen_d   = (head_rd != '0);
            waddr_d = head_rd;
            wdata_d = head_data;
        end else if (take_alu) begin
            wen_d   = (wb.alu_rd != '0);
            waddr_d = wb.alu_rd;
            wdata_d = wb.alu_data;
        end
    end

    always_comb begin
        wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d   = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        starve_d = (fifo_empty || pop) ? '0 : starve_q + 1'b1;
        stall_d  = !fifo_empty && !pop && (starve_q == SW'(STARVE_LIMIT - 1));
    end

    // Clear for the popped entry first so a same-edge issue to that reg wins.
    always_comb begin
        busy_d = busy_q;
        if (pop)
            busy_d[head_rd] = 1'b0;
        if (wb.iss_valid && wb.iss_is_load)
            busy_d[wb.iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= wb.lsu_rd;
            fifo_data_q[wptr_q] <= wb.lsu_data;
        end
    end

    // The ALU has no backpressure path other than alu_stall.
    always_ff @(posedge clk) begin
        if (rst_n && stall_q)
            assert (!wb.alu_valid);
    end

    assign wb.lsu_ready = lsu_ready;
    assign wb.rs1_busy  = busy_q[wb.rs1_addr];
    assign wb.rs2_busy  = busy_q[wb.rs2_addr];
    assign wb.alu_stall = stall_q;
    assign wb.w_en      = wen_q;
    assign wb.wr_addr   = waddr_q;
    assign wb.wr_data   = wdata_q;
    assign wb.buf_count = count_q;
endmodule

// File: tb/tb_ysyx_22050078_wb_unit.sv
// Bench for the writeback unit: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a queue-based model.
module tb_ysyx_22050078_wb_unit;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_22050078_wb_unit_if bus ();

    ysyx_22050078_wb_unit #(
        .ADDR_WIDTH(5), .DATA_WIDTH(64), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wb   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model state: what the write port and queue must look like after each edge.
    ent_t        mq[$];
    logic [31:0] m_busy;
    int          m_starve;
    logic        m_stall, m_wen;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;
    logic [4:0]  pending[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy   = '0;
        m_starve = 0;
        m_stall  = 1'b0;
        m_wen    = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
    endtask

    task automatic model_commit();
        ent_t e;
        logic nonempty, pop, push, nstall;
        if (!rst_n) begin
            model_reset();
            return;
        end
        nonempty = (mq.size() > 0);
        pop      = nonempty && (m_stall || !bus.alu_valid);
        push     = bus.lsu_valid && (mq.size() < DEPTH);
        nstall   = nonempty && !pop && (m_starve == LIMIT - 1);
        if (pop) begin
            e = mq.pop_front();
            m_wen   = (e.rd != 0);
            m_waddr = e.rd;
            m_wdata = e.data;
            m_busy[e.rd] = 1'b0;
        end else if (!m_stall && bus.alu_valid) begin
            m_wen   = (bus.alu_rd != 0);
            m_waddr = bus.alu_rd;
            m_wdata = bus.alu_data;
        end else begin
            m_wen = 1'b0;
        end
        m_starve = (!nonempty || pop) ? 0 : m_starve + 1;
        m_stall  = nstall;
        if (push) begin
            e.rd = bus.lsu_rd;
            e.data = bus.lsu_data;
            mq.push_back(e);
        end
        if (bus.iss_valid && bus.iss_is_load && bus.iss_rd != 0)
            m_busy[bus.iss_rd] = 1'b1;
    endtask

    // Inputs are already applied; checks combinational outputs, clocks, checks state.
    task automatic step();
        #1;
        chk("lsu_ready", 64'(bus.lsu_ready), 64'(rst_n && (mq.size() < DEPTH)));
        chk("rs1_busy", 64'(bus.rs1_busy), 64'(m_busy[bus.rs1_addr]));
        chk("rs2_busy", 64'(bus.rs2_busy), 64'(m_busy[bus.rs2_addr]));
        @(posedge clk);
        model_commit();
        @(negedge clk);
        chk("w_en", 64'(bus.w_en), 64'(m_wen));
        chk("wr_addr", 64'(bus.wr_addr), 64'(m_waddr));
        chk("wr_data", bus.wr_data, m_wdata);
        chk("alu_stall", 64'(bus.alu_stall), 64'(m_stall));
        chk("buf_count", 64'(bus.buf_count), 64'(mq.size()));
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        bus.iss_valid = 1'b0; bus.iss_is_load = 1'b0; bus.iss_rd = '0;
        bus.rs1_addr = '0; bus.rs2_addr = '0;
    endtask

    function automatic logic [4:0] pick_free();
        for (int t = 0; t < 8; t++) begin
            logic [4:0] r;
            r = 5'($urandom_range(31));
            if (!m_busy[r]) return r;
        end
        return 5'd0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic acc;
        idle();
        rst_n = 1'b0;
        bus.lsu_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset held with a load offered
        for (int i = 0; i < 3; i++) step();
        chk("rst_w_en", 64'(bus.w_en), 64'd0);
        chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
        chk("rst_buf_count", 64'(bus.buf_count), 64'd0);
        chk("rst_rs1_busy", 64'(bus.rs1_busy), 64'd0);
        rst_n = 1'b1;
        idle();
        step();

        // ALU path
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h1234;
        step();
        chk("alu_w_en", 64'(bus.w_en), 64'd1);
        chk("alu_wr_addr", 64'(bus.wr_addr), 64'd5);
        chk("alu_wr_data", bus.wr_data, 64'h1234);
        bus.alu_rd = 5'd0; bus.alu_data = 64'h55;
        step();
        chk("alu_rd0_w_en", 64'(bus.w_en), 64'd0);
        idle();

        // Load + scoreboard
        bus.iss_valid = 1'b1; bus.iss_is_load = 1'b1; bus.iss_rd = 5'd7; bus.rs1_addr = 5'd7;
        step();
        chk("ld_busy_set", 64'(bus.rs1_busy), 64'd1);
        bus.iss_valid = 1'b0; bus.iss_is_load = 1'b0;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 64'hDEAD;
        step();
        chk("ld_accept_w_en", 64'(bus.w_en), 64'd0);
        chk("ld_accept_count", 64'(bus.buf_count), 64'd1);
        bus.lsu_valid = 1'b0;
        step();
        chk("ld_w_en", 64'(bus.w_en), 64'd1);
        chk("ld_wr_addr", 64'(bus.wr_addr), 64'd7);
        chk("ld_wr_data", bus.wr_data, 64'hDEAD);
        chk("ld_busy_clear", 64'(bus.rs1_busy), 64'd0);
        idle();

        // Full FIFO under continuous ALU traffic
        bus.alu_rd = 5'd1;
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = !m_stall; bus.alu_data = 64'(100 + i);
            bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(10 + i); bus.lsu_data = 64'(i);
            step();
        end
        chk("full_count", 64'(bus.buf_count), 64'd4);
        chk("full_ready", 64'(bus.lsu_ready), 64'd0);
        bus.lsu_rd = 5'd14; bus.lsu_data = 64'hF5;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 30) begin
            bus.alu_valid = !m_stall;
            acc = (mq.size() < DEPTH);
            step();
            n++;
        end
        chk("full_5th_wait", 64'(n), 64'd7);
        chk("full_5th_count", 64'(bus.buf_count), 64'd4);
        idle();
        for (int i = 0; i < 6; i++) step();
        chk("full_drained", 64'(bus.buf_count), 64'd0);

        // Starvation with one buffered entry
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'h33;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd20; bus.lsu_data = 64'h2020;
        step();
        bus.lsu_valid = 1'b0;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            bus.alu_valid = !m_stall;
            step();
            if (bus.alu_stall === 1'b1) begin
                n = k;
                break;
            end
        end
        chk("starve_cycles", 64'(n), 64'd8);
        bus.alu_valid = 1'b0;
        step();
        chk("starve_w_en", 64'(bus.w_en), 64'd1);
        chk("starve_wr_addr", 64'(bus.wr_addr), 64'd20);
        chk("starve_stall_off", 64'(bus.alu_stall), 64'd0);
        idle();

        // Busy set and cleared for the same register on the same edge
        bus.iss_valid = 1'b1; bus.iss_is_load = 1'b1; bus.iss_rd = 5'd9; bus.rs1_addr = 5'd9;
        step();
        bus.iss_valid = 1'b0;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 64'h99;
        step();
        bus.lsu_valid = 1'b0;
        bus.iss_valid = 1'b1;
        step();
        chk("coll_w_en", 64'(bus.w_en), 64'd1);
        chk("coll_wr_addr", 64'(bus.wr_addr), 64'd9);
        chk("coll_busy", 64'(bus.rs1_busy), 64'd1);
        bus.iss_valid = 1'b0;

        // Reset while entries are buffered
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2;
        for (int i = 0; i < 2; i++) begin
            bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(21 + i); bus.lsu_data = 64'(i + 7);
            step();
        end
        chk("mid_count", 64'(bus.buf_count), 64'd2);
        idle();
        bus.rs1_addr = 5'd9;
        rst_n = 1'b0;
        step();
        chk("mid_rst_count", 64'(bus.buf_count), 64'd0);
        chk("mid_rst_w_en", 64'(bus.w_en), 64'd0);
        chk("mid_rst_busy", 64'(bus.rs1_busy), 64'd0);
        chk("mid_rst_ready", 64'(bus.lsu_ready), 64'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("mid_after_w_en", 64'(bus.w_en), 64'd0);
        chk("mid_after_count", 64'(bus.buf_count), 64'd0);

        // Randomized traffic obeying decode's WAW and alu_stall rules
        pending.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n = !(cyc >= 1500 && cyc < 1502);
            if (!rst_n) pending.delete();
            bus.alu_valid = rst_n && !m_stall && ($urandom_range(99) < 55);
            bus.alu_rd = pick_free();
            bus.alu_data = {$urandom, $urandom};
            bus.iss_valid = rst_n && (pending.size() < 6) && ($urandom_range(99) < 30);
            bus.iss_is_load = ($urandom_range(99) < 70);
            bus.iss_rd = pick_free();
            bus.lsu_valid = rst_n && (pending.size() > 0) && ($urandom_range(99) < 60);
            bus.lsu_rd = (pending.size() > 0) ? pending[0] : 5'd0;
            bus.lsu_data = {$urandom, $urandom};
            bus.rs1_addr = ($urandom_range(1) == 1) ? bus.iss_rd : 5'($urandom_range(31));
            bus.rs2_addr = 5'($urandom_range(31));
            if (bus.iss_valid && bus.iss_rd != 0)
                assert (!m_busy[bus.iss_rd]);
            acc = bus.lsu_valid && (mq.size() < DEPTH);
            step();
            if (acc) void'(pending.pop_front());
            if (rst_n && bus.iss_valid && bus.iss_is_load) pending.push_back(bus.iss_rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
